// File: rtl/neuron_buffer_pingpong.sv
// Ping-pong neuron buffer: the CU reads/writes D-word vectors in the active half
// while a word-serial IO engine loads or unloads the inactive half.
module neuron_buffer_pingpong #(
  parameter int depth = 2,
  parameter int D     = 1 << depth,
  parameter int A     = 7,
  parameter int W     = 16,
  parameter int L     = A + depth + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [A-1:0]     cu_addr,
  input  logic             cu_rd_en,
  input  logic             cu_wr_en,
  input  logic [W*D-1:0]   cu_wdata,
  output logic [W*D-1:0]   cu_rdata,
  output logic             cu_rvalid,
  input  logic             swap_req,
  output logic             active_sel,
  output logic             swap_pending,
  input  logic             io_start,
  input  logic             io_dir,
  input  logic [A-1:0]     io_base,
  input  logic [L-1:0]     io_len,
  input  logic [W-1:0]     io_in_data,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  output logic [W-1:0]     io_out_data,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_busy,
  output logic             io_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UNLD_FETCH, S_UNLD_HOLD, S_DONE
  } state_t;

  localparam logic [L-1:0]     ONE_L     = 1;
  localparam logic [A-1:0]     ONE_A     = 1;
  localparam logic [depth-1:0] ONE_B     = 1;
  localparam logic [depth-1:0] BANK_LAST = '1;

  state_t           state_reg;
  logic             active_reg;
  logic             pending_reg;
  logic             io_half_reg;
  logic [depth-1:0] bank_reg;
  logic [A-1:0]     addr_reg;
  logic [L-1:0]     cnt_reg;
  logic [L-1:0]     len_reg;
  logic             cu_rvalid_reg;

  logic             io_wr;
  logic             io_rd;
  logic             advance;
  logic             last_word;
  logic [D-1:0]     io_wr_sel;
  logic [W-1:0]     io_rd_words [D];

  // The reset gate keeps a load word from landing on the edge that aborts it.
  assign io_wr     = RST_N && (state_reg == S_LOAD) && io_in_valid;
  assign io_rd     = (state_reg == S_UNLD_FETCH);
  assign advance   = io_wr || ((state_reg == S_UNLD_HOLD) && io_out_ready);
  assign last_word = ((cnt_reg + ONE_L) == len_reg);
  assign io_wr_sel = io_wr ? (D'(1) << bank_reg) : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg   <= S_IDLE;
      active_reg  <= 1'b0;
      pending_reg <= 1'b0;
      io_half_reg <= 1'b0;
      bank_reg    <= '0;
      addr_reg    <= '0;
      cnt_reg     <= '0;
      len_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (swap_req) active_reg <= ~active_reg;
          if (io_start) begin
            // A coincident swap toggles first, so target the post-toggle inactive half.
            io_half_reg <= swap_req ? active_reg : ~active_reg;
            addr_reg    <= io_base;
            bank_reg    <= '0;
            cnt_reg     <= '0;
            len_reg     <= io_len;
            if (io_len == '0)  state_reg <= S_DONE;
            else if (io_dir)   state_reg <= S_UNLD_FETCH;
            else               state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (io_in_valid && last_word) state_reg <= S_DONE;
        end
        S_UNLD_FETCH: state_reg <= S_UNLD_HOLD;
        S_UNLD_HOLD: begin
          if (io_out_ready) state_reg <= last_word ? S_DONE : S_UNLD_FETCH;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          if (pending_reg || swap_req) active_reg <= ~active_reg;
        end
        default: state_reg <= S_IDLE;
      endcase

      if (state_reg == S_DONE)
        pending_reg <= 1'b0;
      else if (state_reg != S_IDLE && swap_req)
        pending_reg <= 1'b1;

      // Bank index moves fastest; the row address steps when the bank wraps.
      if (advance) begin
        cnt_reg  <= cnt_reg + ONE_L;
        bank_reg <= bank_reg + ONE_B;
        if (bank_reg == BANK_LAST) addr_reg <= addr_reg + ONE_A;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) cu_rvalid_reg <= 1'b0;
    else        cu_rvalid_reg <= cu_rd_en;
  end

  // Each bank stores both halves; the half select is the top address bit.
  for (genvar gi = 0; gi < D; gi++) begin : g_bank
    logic [W-1:0] mem [0:(2**(A+1))-1];
    logic [W-1:0] cu_q;
    logic [W-1:0] io_q;

    always_ff @(posedge CLK) begin
      if (cu_wr_en)      mem[{active_reg, cu_addr}]   <= cu_wdata[W*gi +: W];
      if (io_wr_sel[gi]) mem[{io_half_reg, addr_reg}] <= io_in_data;
    end

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        cu_q <= '0;
        io_q <= '0;
      end else begin
        if (cu_rd_en) cu_q <= mem[{active_reg, cu_addr}];
        if (io_rd)    io_q <= mem[{io_half_reg, addr_reg}];
      end
    end

    assign cu_rdata[W*gi +: W] = cu_q;
    assign io_rd_words[gi]     = io_q;
  end

  assign cu_rvalid    = cu_rvalid_reg;
  assign active_sel   = active_reg;
  assign swap_pending = pending_reg;
  assign io_out_data  = io_rd_words[bank_reg];
  assign io_in_ready  = (state_reg == S_LOAD);
  assign io_out_valid = (state_reg == S_UNLD_HOLD);
  assign io_busy      = (state_reg != S_IDLE);
  assign io_done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_neuron_buffer_pingpong.sv
// Directed bench for neuron_buffer_pingpong: CU vector table plus IO/swap sequences.
module tb_neuron_buffer_pingpong;

  localparam int depth = 2;
  localparam int D = 4;
  localparam int A = 7;
  localparam int W = 16;
  localparam int L = A + depth + 1;

  logic           clk;
  logic           rst_n;
  logic [A-1:0]   cu_addr;
  logic           cu_rd_en;
  logic           cu_wr_en;
  logic [W*D-1:0] cu_wdata;
  logic [W*D-1:0] cu_rdata;
  logic           cu_rvalid;
  logic           swap_req;
  logic           active_sel;
  logic           swap_pending;
  logic           io_start;
  logic           io_dir;
  logic [A-1:0]   io_base;
  logic [L-1:0]   io_len;
  logic [W-1:0]   io_in_data;
  logic           io_in_valid;
  logic           io_in_ready;
  logic [W-1:0]   io_out_data;
  logic           io_out_valid;
  logic           io_out_ready;
  logic           io_busy;
  logic           io_done;

  int checks = 0;
  int errors = 0;

  neuron_buffer_pingpong #(.depth(depth), .D(D), .A(A), .W(W), .L(L)) dut (
    .CLK(clk), .RST_N(rst_n),
    .cu_addr(cu_addr), .cu_rd_en(cu_rd_en), .cu_wr_en(cu_wr_en),
    .cu_wdata(cu_wdata), .cu_rdata(cu_rdata), .cu_rvalid(cu_rvalid),
    .swap_req(swap_req), .active_sel(active_sel), .swap_pending(swap_pending),
    .io_start(io_start), .io_dir(io_dir), .io_base(io_base), .io_len(io_len),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_out_data(io_out_data), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_busy(io_busy), .io_done(io_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [6:0]  addr;
    logic [63:0] wdata;
    logic        exp_rvalid;
    logic [63:0] exp_rdata;
  } cu_vec_t;

  cu_vec_t vecs [7];

  localparam logic [63:0] X1 = 64'h1004_1003_1002_1001;
  localparam logic [63:0] X2 = 64'h2004_2003_2002_2001;
  localparam logic [63:0] X3 = 64'h3004_3003_3002_3001;

  initial begin
    logic [W-1:0] held;
    int n;
    int done_cnt;

    vecs[0] = '{1'b1, 1'b0, 7'd3,   X1,    1'b0, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 7'd3,   64'h0, 1'b1, X1};
    vecs[2] = '{1'b1, 1'b1, 7'd3,   X2,    1'b1, X1};   // read-before-write
    vecs[3] = '{1'b0, 1'b0, 7'd3,   64'h0, 1'b0, X1};   // rdata holds
    vecs[4] = '{1'b0, 1'b1, 7'd3,   64'h0, 1'b1, X2};
    vecs[5] = '{1'b1, 1'b0, 7'd127, X3,    1'b0, X2};
    vecs[6] = '{1'b0, 1'b1, 7'd127, 64'h0, 1'b1, X3};

    rst_n = 1'b0; cu_addr = '0; cu_rd_en = 1'b0; cu_wr_en = 1'b0; cu_wdata = '0;
    swap_req = 1'b0; io_start = 1'b0; io_dir = 1'b0; io_base = '0; io_len = '0;
    io_in_data = '0; io_in_valid = 1'b0; io_out_ready = 1'b0;

    // Reset state
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_active_sel", active_sel, 0);
    check("rst_io_busy", io_busy, 0);
    check("rst_cu_rvalid", cu_rvalid, 0);
    check("rst_cu_rdata", cu_rdata, 0);
    check("rst_io_out_data", io_out_data, 0);
    check("rst_io_done", io_done, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_io_in_ready", io_in_ready, 0);
    check("rst_io_out_valid", io_out_valid, 0);
    $display("reset: active_sel=%0d io_busy=%0d", active_sel, io_busy);

    // CU vector table on PING
    for (int i = 0; i < 7; i++) begin
      cu_wr_en = vecs[i].wr; cu_rd_en = vecs[i].rd;
      cu_addr = vecs[i].addr; cu_wdata = vecs[i].wdata;
      cyc();
      check("cu_rvalid", cu_rvalid, vecs[i].exp_rvalid);
      check("cu_rdata", cu_rdata, vecs[i].exp_rdata);
      $display("cu vec %0d: wr=%0d rd=%0d addr=%0d rvalid=%0d rdata=%h",
               i, vecs[i].wr, vecs[i].rd, vecs[i].addr, cu_rvalid, cu_rdata);
    end
    cu_wr_en = 1'b0; cu_rd_en = 1'b0;

    // Gapped load of 6 words at base 5 into PONG
    io_dir = 1'b0; io_base = 7'd5; io_len = 10'd6; io_start = 1'b1;
    cyc();
    io_start = 1'b0;
    check("load_busy", io_busy, 1);
    check("load_in_ready", io_in_ready, 1);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      io_in_valid = 1'b0;
      cyc();
      done_cnt += int'(io_done);
      io_in_valid = 1'b1; io_in_data = 16'(16'h10 + k);
      cyc();
      if (k < 5) done_cnt += int'(io_done);
      $display("load word %0d: data=%h", k, 16'h10 + k);
    end
    io_in_valid = 1'b0;
    check("load_no_early_done", done_cnt, 0);
    check("load_done_pulse", io_done, 1);
    cyc();
    check("load_done_single", io_done, 0);
    check("load_idle", io_busy, 0);

    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check("swap_idle_toggle", active_sel, 1);
    cu_rd_en = 1'b1; cu_addr = 7'd5;
    cyc();
    cu_addr = 7'd6;
    check("load_addr5", cu_rdata, 64'h0013_0012_0011_0010);
    cyc();
    cu_rd_en = 1'b0;
    check("load_addr6", cu_rdata[31:0], 32'h0015_0014);

    // Unload 4 words from PING addr 3 with a stall on word 2
    io_dir = 1'b1; io_base = 7'd3; io_len = 10'd4; io_start = 1'b1;
    cyc();
    io_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!io_out_valid && n < 10) begin
        cyc();
        n++;
      end
      check("unld_valid", io_out_valid, 1);
      check("unld_word", io_out_data, 16'(16'h2001 + k));
      if (k == 2) begin
        held = io_out_data;
        for (int s = 0; s < 3; s++) begin
          cyc();
          check("unld_stall_valid", io_out_valid, 1);
          check("unld_stall_data", io_out_data, held);
        end
      end
      $display("unload word %0d: data=%h", k, io_out_data);
      io_out_ready = 1'b1;
      cyc();
      io_out_ready = 1'b0;
      if (k < 3) begin
        check("unld_fetch_gap", io_out_valid, 0);
        check("unld_no_early_done", io_done, 0);
      end
    end
    check("unld_done_pulse", io_done, 1);
    cyc();
    check("unld_idle", io_busy, 0);

    // Two swap requests during a load give one deferred toggle
    io_dir = 1'b0; io_base = 7'd20; io_len = 10'd2; io_start = 1'b1;
    cyc();
    io_start = 1'b0; swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check("pend_set", swap_pending, 1);
    check("pend_no_toggle", active_sel, 1);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0; io_in_valid = 1'b1; io_in_data = 16'h0040;
    cyc();
    io_in_data = 16'h0041;
    cyc();
    io_in_valid = 1'b0;
    check("pend_done", io_done, 1);
    check("pend_in_done_active", active_sel, 1);
    check("pend_in_done_pending", swap_pending, 1);
    cyc();
    check("pend_toggled", active_sel, 0);
    check("pend_cleared", swap_pending, 0);
    cyc();
    check("pend_single_toggle", active_sel, 0);
    $display("swap pending: active_sel=%0d", active_sel);

    // Address wrap: base 127, 8 words into PONG
    io_dir = 1'b0; io_base = 7'd127; io_len = 10'd8; io_start = 1'b1;
    cyc();
    io_start = 1'b0; io_in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      io_in_data = 16'(16'h30 + k);
      cyc();
    end
    io_in_valid = 1'b0;
    check("wrap_done", io_done, 1);
    cyc();
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check("wrap_swap", active_sel, 1);
    cu_rd_en = 1'b1; cu_addr = 7'd127;
    cyc();
    cu_addr = 7'd0;
    check("wrap_addr127", cu_rdata, 64'h0033_0032_0031_0030);
    cyc();
    cu_rd_en = 1'b0;
    check("wrap_addr0", cu_rdata, 64'h0037_0036_0035_0034);

    // Zero-length transfer: straight to DONE, no write to PING addr 20
    io_dir = 1'b0; io_base = 7'd20; io_len = 10'd0; io_start = 1'b1;
    io_in_valid = 1'b1; io_in_data = 16'hBEEF;
    cyc();
    io_start = 1'b0;
    check("len0_done", io_done, 1);
    check("len0_busy", io_busy, 1);
    check("len0_in_ready", io_in_ready, 0);
    cyc();
    io_in_valid = 1'b0;
    check("len0_done_single", io_done, 0);
    check("len0_idle", io_busy, 0);
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check("len0_swap", active_sel, 0);
    cu_rd_en = 1'b1; cu_addr = 7'd20;
    cyc();
    cu_rd_en = 1'b0;
    check("len0_mem_intact", cu_rdata[31:0], 32'h0041_0040);

    // Reset in the middle of a load
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    check("mid_rst_pre_active", active_sel, 1);
    io_dir = 1'b0; io_base = 7'd50; io_len = 10'd4; io_start = 1'b1;
    cyc();
    io_start = 1'b0; io_in_valid = 1'b1; io_in_data = 16'h0055; swap_req = 1'b1;
    cyc();
    io_in_valid = 1'b0; swap_req = 1'b0;
    check("mid_rst_busy", io_busy, 1);
    check("mid_rst_pending", swap_pending, 1);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_idle", io_busy, 0);
    check("mid_rst_active", active_sel, 0);
    check("mid_rst_pending_clr", swap_pending, 0);
    check("mid_rst_no_done", io_done, 0);
    check("mid_rst_in_ready", io_in_ready, 0);
    check("mid_rst_cu_rdata", cu_rdata, 0);
    rst_n = 1'b1;
    cyc();
    check("post_rst_no_done", io_done, 0);
    check("post_rst_idle", io_busy, 0);
    $display("reset mid-load: io_busy=%0d active_sel=%0d", io_busy, active_sel);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
